// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: self-timed scanner for common-anode seven-segment displays.
// A prescaler divides clk into digit slots, and a slot counter walks 0..N_DIGITS-1.
// Anode, segment and decimal-point drives are all registered and active-low.
// Optional feature macro: DISPLAY_GHOST_BLANK_EN. When it is defined, the anodes
// are blanked for the first GUARD_CYCLES cycles of every slot.
module display_scan_ctrl #(
   parameter int N_DIGITS     = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              en,
   input  logic [4*N_DIGITS-1:0]                             digits_in,
   input  logic [N_DIGITS-1:0]                               dp_in,
   input  logic [N_DIGITS-1:0]                               digit_en,
   output logic [N_DIGITS-1:0]                               anode_out,
   output logic [6:0]                                        seg_out,
   output logic                                              dp_out,
   output logic [((N_DIGITS > 2) ? $clog2(N_DIGITS) : 1)-1:0] sel_out,
   output logic                                              frame_tick
);

   localparam int SEL_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
   localparam int PW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);
   localparam logic [PW-1:0]    PRE_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]       presc;
   logic [PW-1:0]       presc_n;
   logic [SEL_W-1:0]    sel_n;
   logic                tc;
   logic                wrap;
   logic                lit;
   logic                anode_on;
   logic [3:0]          nib;
   logic [N_DIGITS-1:0] anode_n;

   // Hex nibble to active-low {g,f,e,d,c,b,a} glyph
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Next prescaler and slot values; both freeze while en is low
   always_comb begin
      tc      = en && (presc == PRE_LAST);
      wrap    = tc && (sel_out == SEL_LAST);
      presc_n = presc;
      sel_n   = sel_out;
      if (en) presc_n = tc ? '0 : presc + 1'b1;
      if (tc) sel_n = wrap ? '0 : sel_out + 1'b1;
   end

   // Drive values for the slot that becomes current on this edge
   always_comb begin
      anode_n = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (int'(sel_n) == N_DIGITS - 1 - k) anode_n[k] = 1'b0;
      end
      nib = digits_in[4*int'(sel_n) +: 4];
      lit = en && digit_en[sel_n];
`ifdef DISPLAY_GHOST_BLANK_EN
      anode_on = lit && (presc_n >= PW'(GUARD_CYCLES));
`else
      anode_on = lit;
`endif
   end

   // Counters and output registers, all updated on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         sel_out    <= '0;
         anode_out  <= '1;
         seg_out    <= 7'h7F;
         dp_out     <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         presc      <= presc_n;
         sel_out    <= sel_n;
         frame_tick <= wrap;
         anode_out  <= anode_on ? anode_n : '1;
         seg_out    <= lit ? hex_to_seg(nib) : 7'h7F;
         dp_out     <= lit ? ~dp_in[sel_n] : 1'b1;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl. N_DIGITS is 8, REFRESH_DIV is 4 and GUARD_CYCLES is 1.
// The reference model counts enabled cycles since reset. It derives the slot,
// the tick and the drives arithmetically from that count.
module tb_display_scan_ctrl;

   localparam int N   = 8;
   localparam int DIV = 4;
   localparam int GRD = 1;

   logic          clk = 1'b0;
   logic          rst, en;
   logic [31:0]   digits_in;
   logic [7:0]    dp_in, digit_en;
   logic [7:0]    anode_out;
   logic [6:0]    seg_out;
   logic          dp_out;
   logic [2:0]    sel_out;
   logic          frame_tick;

   int n_chk  = 0;
   int n_fail = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   display_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(GRD)) dut (
      .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
      .digit_en(digit_en), .anode_out(anode_out), .seg_out(seg_out), .dp_out(dp_out),
      .sel_out(sel_out), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   int         t;
   int         s;
   bit         mvalid = 1'b0;
   logic [7:0] e_anode;
   logic [6:0] e_seg;
   logic       e_dp, e_tick;
   logic [2:0] e_sel;

   always @(posedge clk) begin
      if (rst) begin
         t = 0; mvalid = 1'b1;
         e_sel = 3'd0; e_anode = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      end else if (mvalid && en) begin
         t = t + 1;
         s = (t / DIV) % N;
         e_sel = 3'(s);
         e_tick = ((t % (DIV * N)) == 0);
         if (digit_en[s]) begin
            e_anode = 8'hFF;
            e_anode[N-1-s] = 1'b0;
`ifdef DISPLAY_GHOST_BLANK_EN
            if ((t % DIV) < GRD) e_anode = 8'hFF;
`endif
            e_seg = glyph[(digits_in >> (4 * s)) & 32'hF];
            e_dp  = ~dp_in[s];
         end else begin
            e_anode = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
         end
      end else if (mvalid) begin
         e_tick = 1'b0; e_anode = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end
   end

   // Compare DUT against the model on every cycle after the first reset
   always @(negedge clk) begin
      if (mvalid) begin
         chk("anode", 32'(anode_out), 32'(e_anode));
         chk("seg", 32'(seg_out), 32'(e_seg));
         chk("dp", 32'(dp_out), 32'(e_dp));
         chk("sel", 32'(sel_out), 32'(e_sel));
         chk("frame_tick", 32'(frame_tick), 32'(e_tick));
      end
   end

   task automatic wait_sel(input logic [2:0] v);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sel_out == v) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_chk++; n_fail++;
         $display("FAIL wait_sel timeout: sel_out %0d never reached %0d", sel_out, v);
      end
   endtask

   initial begin
      int ticks, cnt;
      rst = 1'b1; en = 1'b0;
      digits_in = 32'h76543210; dp_in = 8'h01; digit_en = 8'hFF;
      repeat (2) @(negedge clk);
      chk("reset anode", 32'(anode_out), 32'hFF);
      chk("reset seg", 32'(seg_out), 32'h7F);
      chk("reset dp", 32'(dp_out), 32'h1);
      chk("reset sel", 32'(sel_out), 32'h0);
      chk("reset tick", 32'(frame_tick), 32'h0);
      rst = 1'b0; en = 1'b1;

      // Mapping and decode
      @(negedge clk);
      chk("slot0 sel", 32'(sel_out), 32'h0);
      chk("slot0 anode", 32'(anode_out), 32'h7F);
      chk("slot0 seg", 32'(seg_out), 32'h40);
      chk("slot0 dp", 32'(dp_out), 32'h0);
      wait_sel(3'd3);
      @(negedge clk);
      chk("slot3 anode", 32'(anode_out), 32'hEF);
      chk("slot3 seg", 32'(seg_out), 32'h30);
      chk("slot3 dp", 32'(dp_out), 32'h1);

      // Frame tick rate
      ticks = 0;
      repeat (64) begin
         @(negedge clk);
         if (frame_tick) ticks++;
      end
      chk("ticks per 64", 32'(ticks), 32'd2);

      // Digit mask
      digit_en = 8'hFB;
      wait_sel(3'd2);
      chk("masked anode", 32'(anode_out), 32'hFF);
      chk("masked seg", 32'(seg_out), 32'h7F);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sel_out != 3'd2) break;
         cnt++;
      end
      chk("masked slot length", 32'(cnt), 32'd4);
      chk("after masked sel", 32'(sel_out), 32'd3);
      digit_en = 8'hFF;

      // Enable hold at slot 5, prescaler 2
      wait_sel(3'd5);
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("hold sel", 32'(sel_out), 32'd5);
      chk("hold anode", 32'(anode_out), 32'hFF);
      chk("hold seg", 32'(seg_out), 32'h7F);
      chk("hold dp", 32'(dp_out), 32'h1);
      en = 1'b1;
      @(negedge clk);
      chk("resume sel a", 32'(sel_out), 32'd5);
      @(negedge clk);
      chk("resume sel b", 32'(sel_out), 32'd6);

      // Reset mid-scan
      rst = 1'b1;
      @(negedge clk);
      chk("midrst sel", 32'(sel_out), 32'd0);
      chk("midrst anode", 32'(anode_out), 32'hFF);
      rst = 1'b0;
      @(negedge clk);
      chk("restart sel", 32'(sel_out), 32'd0);
      chk("restart seg", 32'(seg_out), 32'h40);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         digits_in = $urandom;
         dp_in     = 8'($urandom);
         digit_en  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         en        = ($urandom_range(0, 7) != 0);
         rst       = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
